cvxif_mm_responder: RTL and testbench

CVXIF_MM_RESPONDER -- requirements
Module: cvxif_mm_responder

---
 rtl/mm_cvxif_pkg.sv | 34 +++
 rtl/mm_mac_unit.sv | 51 +++++
 rtl/cvxif_mm_responder.sv | 150 +++++++++++++++
 tb/tb_cvxif_mm_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_cvxif_pkg.sv
// -----------------------------------------------------------------------------
// mm_cvxif_pkg
// Shared definitions for the CVXIF multiply-accumulate responder:
//   - MM_OPCODE          : custom-0 major opcode claimed by the responder
//   - funct3_e           : MAC / CLR / RDACC sub-operations
//   - state_e            : IDLE / EXEC / RESP responder states
//   - MM_MAC_LAT_DEFAULT : default number of EXEC cycles for a MAC
//   - is_mm_instr()      : instruction recognition (opcode, funct7, funct3)
// -----------------------------------------------------------------------------
package mm_cvxif_pkg;

    localparam logic [6:0] MM_OPCODE          = 7'b0001011;
    localparam int         MM_MAC_LAT_DEFAULT = 3;

    typedef enum logic [2:0] {
        F3_MAC   = 3'b000,
        F3_CLR   = 3'b001,
        F3_RDACC = 3'b010
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_mm_instr(input logic [31:0] instr);
        logic [2:0] f3;
        f3 = instr[14:12];
        return (instr[6:0] == MM_OPCODE) && (instr[31:25] == 7'd0) &&
               ((f3 == F3_MAC) || (f3 == F3_CLR) || (f3 == F3_RDACC));
    endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// -----------------------------------------------------------------------------
// mm_mac_unit
// Combinational multiply-add: o_acc_next = i_acc + signed(i_a) * signed(i_b).
// The accumulator register lives in the parent; this block only computes the
// next value.
//
// Ports:
//   i_acc      [63:0] current accumulator
//   i_a, i_b   [31:0] signed 32-bit operands
//   o_acc_next [63:0] accumulator after the multiply-add
//
// Configuration:
//   MM_RESP_SATURATE_EN defined   : signed overflow of the add clamps to the
//                                   most positive / most negative 64-bit value
//   MM_RESP_SATURATE_EN undefined : the add wraps modulo 2^64
// -----------------------------------------------------------------------------
module mm_mac_unit
    import mm_cvxif_pkg::*;
(
    input  logic [63:0] i_acc,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_acc_next
);

    logic signed [31:0] w_a;
    logic signed [31:0] w_b;
    logic signed [63:0] w_prod;

    assign w_a = i_a;
    assign w_b = i_b;

    // Size casts of signed operands sign-extend, so the product is exact.
    assign w_prod = 64'(w_a) * 64'(w_b);

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b);
        logic signed [63:0] s;
        s = a + b;
`ifdef MM_RESP_SATURATE_EN
        // Overflow only when both addends share a sign the sum does not.
        if ((a[63] == b[63]) && (s[63] != a[63])) begin
            s = a[63] ? 64'sh8000_0000_0000_0000 : 64'sh7FFF_FFFF_FFFF_FFFF;
        end
`endif
        return s;
    endfunction

    assign o_acc_next = sat_add(i_acc, w_prod);

endmodule

// File: rtl/cvxif_mm_responder.sv
// -----------------------------------------------------------------------------
// cvxif_mm_responder
// CVXIF coprocessor responder implementing a 64-bit multiply-accumulator with
// three custom instructions (MAC, CLR, RDACC). One instruction is outstanding
// at a time: issue is only offered in IDLE, results are held in RESP until the
// core takes them.
//
// Parameters: XLEN (operand/result width, >= 32), ID_WIDTH, MAC_LAT (1..15)
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   issue_valid_i/issue_ready_o  issue handshake (ready only in IDLE)
//   issue_instr_i, issue_id_i    instruction word and transaction id
//   rs1_i, rs2_i                 source operands (low 32 bits used)
//   issue_accept_o               instruction recognised (combinational)
//   issue_writeback_o            a result will be returned (= accept)
//   result_valid_o/result_ready_i result handshake (valid only in RESP)
//   result_id_o, result_data_o   echoed id and result value
//   result_rd_o, result_we_o     destination register and its write enable
//
// Configuration: define MM_RESP_SATURATE_EN to saturate the MAC add instead of
// wrapping (handled in mm_mac_unit).
// -----------------------------------------------------------------------------
module cvxif_mm_responder
    import mm_cvxif_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 2,
    parameter int MAC_LAT  = MM_MAC_LAT_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o
);

    // Counter is loaded with MAC_LAT-1 so EXEC lasts exactly MAC_LAT cycles.
    localparam logic [3:0] LAT_LOAD = 4'(MAC_LAT - 1);

    state_e              r_state;
    logic [3:0]          r_cnt;
    logic [63:0]         r_acc;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic [ID_WIDTH-1:0] r_res_id;
    logic [XLEN-1:0]     r_res_data;
    logic [4:0]          r_res_rd;
    logic                r_res_we;

    logic                w_xfer;
    funct3_e             w_funct3;
    logic [63:0]         w_mac_acc;
    logic                w_unused_bits;

    // Gating with rst_i keeps ready low during reset and lets it rise on the
    // first cycle after reset is released, without waiting for a clock edge.
    assign issue_ready_o     = (r_state == IDLE) && !rst_i;
    assign issue_accept_o    = is_mm_instr(issue_instr_i);
    assign issue_writeback_o = issue_accept_o;
    assign w_xfer            = issue_valid_i && issue_ready_o;
    assign w_funct3          = funct3_e'(issue_instr_i[14:12]);

    assign result_valid_o = (r_state == RESP);
    assign result_id_o    = r_res_id;
    assign result_data_o  = r_res_data;
    assign result_rd_o    = r_res_rd;
    assign result_we_o    = r_res_we;

    assign w_unused_bits = ^{rs1_i[XLEN-1:32], rs2_i[XLEN-1:32], issue_instr_i[24:15]};

    mm_mac_unit u_mac (
        .i_acc      (r_acc),
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .o_acc_next (w_mac_acc)
    );

    // Operand capture: pure data, no reset needed, only read during EXEC.
    always_ff @(posedge clk_i) begin
        if (w_xfer) begin
            r_op_a <= rs1_i[31:0];
            r_op_b <= rs2_i[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_res_id   <= '0;
            r_res_data <= '0;
            r_res_rd   <= '0;
            r_res_we   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer && issue_accept_o) begin
                        r_res_id <= issue_id_i;
                        r_res_rd <= issue_instr_i[11:7];
                        r_res_we <= |issue_instr_i[11:7];
                        case (w_funct3)
                            F3_MAC: begin
                                r_cnt   <= LAT_LOAD;
                                r_state <= EXEC;
                            end
                            F3_CLR: begin
                                r_acc      <= '0;
                                r_res_data <= '0;
                                r_state    <= RESP;
                            end
                            default: begin
                                r_res_data <= XLEN'($signed(r_acc));
                                r_state    <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_acc      <= w_mac_acc;
                        r_res_data <= XLEN'($signed(w_mac_acc));
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (result_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cvxif_mm_responder.sv
// -----------------------------------------------------------------------------
// tb_cvxif_mm_responder
// Directed bench for cvxif_mm_responder with default parameters
// (XLEN=64, ID_WIDTH=2, MAC_LAT=3). Honours MM_RESP_SATURATE_EN for the
// overflow expectation.
// -----------------------------------------------------------------------------
module tb_cvxif_mm_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [1:0]  issue_id_i;
    logic [63:0] rs1_i;
    logic [63:0] rs2_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [1:0]  result_id_o;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    int n_checks = 0;
    int n_fail   = 0;

    cvxif_mm_responder #(
        .XLEN     (64),
        .ID_WIDTH (2),
        .MAC_LAT  (3)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .rs1_i             (rs1_i),
        .rs2_i             (rs2_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 10'd0, f3, rd, 7'b0001011};
    endfunction

    // Present one instruction for a single cycle, then scramble the inputs so
    // any late sampling of them shows up in the result.
    task automatic issue(input logic [31:0] instr, input logic [1:0] id,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk_i);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_id_i    = id;
        rs1_i         = a;
        rs2_i         = b;
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        issue_instr_i = $urandom;
        issue_id_i    = 2'($urandom);
        rs1_i         = {$urandom, $urandom};
        rs2_i         = {$urandom, $urandom};
    endtask

    // Called #1 after the transfer edge; latency counts edges from transfer.
    task automatic expect_result(input string tag, input int exp_lat, input logic [63:0] exp_data,
                                 input logic [1:0] exp_id, input logic [4:0] exp_rd,
                                 input logic exp_we);
        int n;
        n = 0;
        while (result_valid_o !== 1'b1 && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (result_valid_o !== 1'b1) begin
            check_val({tag, "_timeout"}, 64'(result_valid_o), 64'd1);
            return;
        end
        check_val({tag, "_lat"},   64'(n + 1),         64'(exp_lat));
        check_val({tag, "_data"},  result_data_o,      exp_data);
        check_val({tag, "_id"},    64'(result_id_o),   64'(exp_id));
        check_val({tag, "_rd"},    64'(result_rd_o),   64'(exp_rd));
        check_val({tag, "_we"},    64'(result_we_o),   64'(exp_we));
        check_val({tag, "_irdy"},  64'(issue_ready_o), 64'd0);
        if (result_ready_i) begin
            @(posedge clk_i);
            #1;
            check_val({tag, "_done_vld"}, 64'(result_valid_o), 64'd0);
            check_val({tag, "_done_rdy"}, 64'(issue_ready_o),  64'd1);
        end
    endtask

    initial begin
        logic [63:0] exp_third;

        rst_i          = 1'b1;
        issue_valid_i  = 1'b0;
        issue_instr_i  = '0;
        issue_id_i     = '0;
        rs1_i          = '0;
        rs2_i          = '0;
        result_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_irdy", 64'(issue_ready_o),  64'd0);
        check_val("rst_vld",  64'(result_valid_o), 64'd0);
        check_val("rst_data", result_data_o,       64'd0);
        check_val("rst_id",   64'(result_id_o),    64'd0);
        check_val("rst_rd",   64'(result_rd_o),    64'd0);
        check_val("rst_we",   64'(result_we_o),    64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_val("post_rst_irdy", 64'(issue_ready_o), 64'd1);

        // MAC 3 * -4 = -12
        issue(mk(3'b000, 5'd5), 2'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_result("mac1", 4, 64'hFFFF_FFFF_FFFF_FFF4, 2'd2, 5'd5, 1'b1);

        // MAC 16 * 2 with junk in the upper halves: -12 + 32 = 20
        issue(mk(3'b000, 5'd31), 2'd1, 64'hAAAA_AAAA_0000_0010, 64'h5555_5555_0000_0002);
        expect_result("mac2", 4, 64'h14, 2'd1, 5'd31, 1'b1);

        issue(mk(3'b010, 5'd7), 2'd3, 64'd0, 64'd0);
        expect_result("rdacc1", 1, 64'h14, 2'd3, 5'd7, 1'b1);

        // Decode: accepted and rejected encodings
        @(negedge clk_i);
        issue_instr_i = mk(3'b000, 5'd1);
        #1;
        check_val("acc_mac", 64'(issue_accept_o),    64'd1);
        check_val("wb_mac",  64'(issue_writeback_o), 64'd1);
        issue_instr_i = 32'h0000_02B3;
        #1;
        check_val("acc_op33", 64'(issue_accept_o),    64'd0);
        check_val("wb_op33",  64'(issue_writeback_o), 64'd0);
        issue_instr_i = mk(3'b000, 5'd1) | 32'h0200_0000;
        #1;
        check_val("acc_f7", 64'(issue_accept_o), 64'd0);
        issue_instr_i = mk(3'b011, 5'd1);
        #1;
        check_val("acc_f3", 64'(issue_accept_o), 64'd0);

        // Unaccepted transfer: no result, stays ready, acc untouched
        issue(32'h0000_02B3, 2'd1, 64'd5, 64'd5);
        for (int i = 0; i < 6; i++) begin
            check_val("rej_vld",  64'(result_valid_o), 64'd0);
            check_val("rej_irdy", 64'(issue_ready_o),  64'd1);
            @(posedge clk_i);
            #1;
        end
        issue(mk(3'b010, 5'd6), 2'd0, 64'd0, 64'd0);
        expect_result("rdacc_rej", 1, 64'h14, 2'd0, 5'd6, 1'b1);

        // CLR, then RDACC to x0
        issue(mk(3'b001, 5'd3), 2'd0, 64'd0, 64'd0);
        expect_result("clr", 1, 64'd0, 2'd0, 5'd3, 1'b1);
        issue(mk(3'b010, 5'd0), 2'd1, 64'd0, 64'd0);
        expect_result("rdacc_x0", 1, 64'd0, 2'd1, 5'd0, 1'b0);

        // Back-pressure: result held while result_ready_i is low
        result_ready_i = 1'b0;
        issue(mk(3'b000, 5'd9), 2'd2, 64'd5, 64'd7);
        expect_result("hold", 4, 64'h23, 2'd2, 5'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check_val("hold_vld",  64'(result_valid_o), 64'd1);
            check_val("hold_data", result_data_o,       64'h23);
            check_val("hold_id",   64'(result_id_o),    64'd2);
            check_val("hold_rd",   64'(result_rd_o),    64'd9);
            check_val("hold_we",   64'(result_we_o),    64'd1);
            check_val("hold_irdy", 64'(issue_ready_o),  64'd0);
        end
        @(negedge clk_i);
        result_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_val("hold_rel_vld",  64'(result_valid_o), 64'd0);
        check_val("hold_rel_irdy", 64'(issue_ready_o),  64'd1);

        // Signed overflow on the third accumulation
`ifdef MM_RESP_SATURATE_EN
        exp_third = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_third = 64'hBFFF_FFFD_0000_0003;
`endif
        issue(mk(3'b001, 5'd1), 2'd0, 64'd0, 64'd0);
        expect_result("ovf_clr", 1, 64'd0, 2'd0, 5'd1, 1'b1);
        issue(mk(3'b000, 5'd2), 2'd1, 64'h7FFF_FFFF, 64'h7FFF_FFFF);
        expect_result("ovf1", 4, 64'h3FFF_FFFF_0000_0001, 2'd1, 5'd2, 1'b1);
        issue(mk(3'b000, 5'd2), 2'd2, 64'h7FFF_FFFF, 64'h7FFF_FFFF);
        expect_result("ovf2", 4, 64'h7FFF_FFFE_0000_0002, 2'd2, 5'd2, 1'b1);
        issue(mk(3'b000, 5'd2), 2'd3, 64'h7FFF_FFFF, 64'h7FFF_FFFF);
        expect_result("ovf3", 4, exp_third, 2'd3, 5'd2, 1'b1);

        // Reset in the middle of EXEC abandons the MAC and clears acc
        issue(mk(3'b000, 5'd4), 2'd1, 64'd1, 64'd2);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_val("mrst_vld",  64'(result_valid_o), 64'd0);
        check_val("mrst_irdy", 64'(issue_ready_o),  64'd0);
        check_val("mrst_data", result_data_o,       64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_val("mrst_post_irdy", 64'(issue_ready_o), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            check_val("mrst_no_vld", 64'(result_valid_o), 64'd0);
        end
        issue(mk(3'b010, 5'd2), 2'd0, 64'd0, 64'd0);
        expect_result("mrst_rdacc", 1, 64'd0, 2'd0, 5'd2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
